mac_seq_ctrl: RTL

Sequencer for the pipelined MAC unit (4-stage multiplier, accumulate enable delayed 4 cycles, immediate init). The block accepts one dot-product job at a time: a tap count plus a bias. It initialises the accumulator with the bias and streams operand pairs into the MAC under valid/ready. It then waits out the multiplier pipeline and presents the final accumulator value on an output handshake. It sits between the convolution window/weight fetch logic and one MAC instance.

---
 rtl/mac_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for a pipelined MAC unit.
// Accepts one dot-product job (tap count + bias), initialises the MAC accumulator with the bias,
// streams operand pairs under valid/ready, waits out the multiplier pipeline, then presents the
// accumulator on a result handshake.
// Optional build macro MAC_SEQ_CTRL_RELU_EN: clamp negative results to zero in DONE.
module mac_seq_ctrl #(
  parameter int unsigned INW  = 24,
  parameter int unsigned OUTW = 48,
  parameter int unsigned MAXK = 16,
  parameter int unsigned LAT  = 4,
  localparam int unsigned LW  = $clog2(MAXK + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // Job handshake
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [LW-1:0]   cfg_len_i,
  input  logic [INW-1:0]  cfg_bias_i,
  // Operand-pair handshake
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [INW-1:0]  in_a_i,
  input  logic [INW-1:0]  in_b_i,
  // MAC interface
  output logic [INW-1:0]  mac_input0_o,
  output logic [INW-1:0]  mac_input1_o,
  output logic [INW-1:0]  mac_init_value_o,
  output logic            mac_init_acc_o,
  output logic            mac_input_valid_o,
  input  logic [OUTW-1:0] mac_out_i,
  // Result handshake
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [OUTW-1:0] out_data_o,
  output logic            busy_o
);

  localparam int unsigned DW = (LAT > 1) ? $clog2(LAT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StInit, StStream, StDrain, StDone} state_e;

  state_e          state_q;
  logic [LW-1:0]   rem_q;
  logic [DW-1:0]   drain_q;
  logic [INW-1:0]  bias_q;
  logic            cfg_ready_q;
  logic            in_ready_q;
  logic            init_acc_q;
  logic            out_valid_q;
  logic            busy_q;

  logic            cfg_fire;
  logic            in_fire;
  logic            out_fire;
  logic [LW-1:0]   len_clamped;

  assign cfg_fire    = cfg_valid_i & cfg_ready_q;
  assign in_fire     = in_valid_i & in_ready_q;
  assign out_fire    = out_valid_q & out_ready_i;
  assign len_clamped = (cfg_len_i > LW'(MAXK)) ? LW'(MAXK) : cfg_len_i;

  assign cfg_ready_o       = cfg_ready_q;
  assign in_ready_o        = in_ready_q;
  assign mac_input0_o      = in_a_i;
  assign mac_input1_o      = in_b_i;
  assign mac_input_valid_o = in_fire;
  assign mac_init_value_o  = bias_q;
  assign mac_init_acc_o    = init_acc_q;
  assign out_valid_o       = out_valid_q;
  assign busy_o            = busy_q;

  // Job sequencing FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      drain_q     <= '0;
      bias_q      <= '0;
      cfg_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      init_acc_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Reset leaves cfg_ready low; it rises on the first edge after release.
          cfg_ready_q <= 1'b1;
          if (cfg_fire) begin
            rem_q       <= len_clamped;
            bias_q      <= cfg_bias_i;
            cfg_ready_q <= 1'b0;
            init_acc_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StInit;
          end
        end
        StInit: begin
          init_acc_q <= 1'b0;
          if (rem_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= StStream;
          end
        end
        StStream: begin
          if (in_fire) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LW'(1)) begin
              in_ready_q <= 1'b0;
              drain_q    <= DW'(LAT);
              state_q    <= StDrain;
            end
          end
        end
        StDrain: begin
          // Wait until the last product has been accumulated so mac_out is final.
          drain_q <= drain_q - 1'b1;
          if (drain_q == DW'(1)) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result gating: zero outside DONE, optionally clamped at zero for negative sums.
  always_comb begin
    out_data_o = '0;
    if (out_valid_q) begin
`ifdef MAC_SEQ_CTRL_RELU_EN
      if (!mac_out_i[OUTW-1]) begin
        out_data_o = mac_out_i;
      end
`else
      out_data_o = mac_out_i;
`endif
    end
  end

endmodule
